// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, drives the program
// memory address and captures the returned word into the instruction
// register. Handles stall, absolute/relative branch redirect with squash
// of the in-flight word, and halting on a reserved instruction encoding.
module fetch_unit #(
   parameter int                P_SIZE     = 6,
   parameter int                I_SIZE     = 24,
   parameter logic [P_SIZE-1:0] RESET_ADDR = '0,
   parameter logic [I_SIZE-1:0] HALT_WORD  = {I_SIZE{1'b1}}
) (
   input  logic              clk,
   input  logic              reset,
   output logic [P_SIZE-1:0] address,
   input  logic [I_SIZE-1:0] instruction,
   input  logic              stall,
   input  logic              branch_rel,
   input  logic              branch_abs,
   input  logic [P_SIZE-1:0] branch_offset,
   input  logic [P_SIZE-1:0] branch_target,
   output logic [I_SIZE-1:0] ir,
   output logic [P_SIZE-1:0] ir_pc,
   output logic              ir_valid,
   output logic              halted
);

   localparam logic [0:0] S_RUN  = 1'b0;
   localparam logic [0:0] S_HALT = 1'b1;

   logic [0:0]        r_state;
   logic [P_SIZE-1:0] r_pc;
   logic [I_SIZE-1:0] r_ir;
   logic [P_SIZE-1:0] r_ir_pc;
   logic              r_ir_valid;
   logic              r_halted;

   // Relative target is computed from the PC of the word in IR (the branch
   // instruction itself); the two's-complement add wraps modulo 2^P_SIZE,
   // which gives the sign extension for free.
   logic [P_SIZE-1:0] w_rel_target;
   logic [P_SIZE-1:0] w_pc_inc;
   logic              w_is_halt;

   assign w_rel_target = r_ir_pc + branch_offset;
   assign w_pc_inc     = r_pc + 1'b1;
   assign w_is_halt    = (instruction == HALT_WORD);

   // Address comes from the PC register only; stall/branch act on the next edge.
   assign address  = r_pc;
   assign ir       = r_ir;
   assign ir_pc    = r_ir_pc;
   assign ir_valid = r_ir_valid;
   assign halted   = r_halted;

   // Fetch state machine: branch_abs > branch_rel > stall > normal fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_RUN;
         r_pc       <= RESET_ADDR;
         r_ir       <= '0;
         r_ir_pc    <= '0;
         r_ir_valid <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (branch_abs) begin
                  // word on the bus this cycle is squashed; IR keeps the branch
                  r_pc       <= branch_target;
                  r_ir_valid <= 1'b0;
               end else if (branch_rel) begin
                  r_pc       <= w_rel_target;
                  r_ir_valid <= 1'b0;
               end else if (!stall) begin
                  r_ir       <= instruction;
                  r_ir_pc    <= r_pc;
                  r_ir_valid <= 1'b1;
                  if (w_is_halt) begin
                     // PC parks on the halt word so address stays there
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_pc <= w_pc_inc;
                  end
               end
            end
            default: begin
               // halted: everything frozen except that IR stops being issued
               r_ir_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, hand-written
// halt/reset sequences and a randomized run, all compared each cycle
// against a rule-level reference model of the fetch stage.
module tb_fetch_unit;
   localparam logic [23:0] HW = 24'hFFFFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b0, stall = 1'b0, branch_rel = 1'b0, branch_abs = 1'b0;
   logic [5:0]  branch_offset = '0, branch_target = '0;
   logic [5:0]  address, ir_pc;
   logic [23:0] instruction, ir;
   logic        ir_valid, halted;

   logic [23:0] mem [64];
   assign instruction = mem[address];

   always #5 clk = ~clk;

   fetch_unit #(.P_SIZE(6), .I_SIZE(24), .RESET_ADDR(6'd0), .HALT_WORD(HW)) dut (
      .clk(clk), .reset(reset), .address(address), .instruction(instruction),
      .stall(stall), .branch_rel(branch_rel), .branch_abs(branch_abs),
      .branch_offset(branch_offset), .branch_target(branch_target),
      .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted));

   int errors = 0;
   int checks = 0;

   // reference model: the architectural view of the fetch stage
   int          m_pc, m_irpc;
   logic [23:0] m_ir;
   bit          m_v, m_h;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, st, brel, babs, input logic [5:0] off, tgt);
      int t;
      if (rst) begin
         m_pc = 0; m_ir = '0; m_irpc = 0; m_v = 0; m_h = 0;
      end else if (m_h) begin
         m_v = 0;
      end else if (babs) begin
         m_pc = int'(tgt); m_v = 0;
      end else if (brel) begin
         t = m_irpc + int'($signed(off));
         m_pc = ((t % 64) + 64) % 64;
         m_v = 0;
      end else if (!st) begin
         m_ir = mem[m_pc]; m_irpc = m_pc; m_v = 1;
         if (mem[m_pc] == HW) m_h = 1;
         else m_pc = (m_pc + 1) % 64;
      end
   endtask

   // apply one cycle of inputs, advance model, compare after the edge
   task automatic cycle(input bit rst, st, brel, babs, input logic [5:0] off, tgt);
      reset = rst; stall = st; branch_rel = brel; branch_abs = babs;
      branch_offset = off; branch_target = tgt;
      model_step(rst, st, brel, babs, off, tgt);
      @(posedge clk); #1;
      chk("address", 32'(address), 32'(m_pc));
      chk("ir", 32'(ir), 32'(m_ir));
      chk("ir_pc", 32'(ir_pc), 32'(m_irpc));
      chk("ir_valid", 32'(ir_valid), 32'(m_v));
      chk("halted", 32'(halted), 32'(m_h));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 6'd0, 6'd0);
   endtask

   typedef struct {
      bit          rst, st, brel, babs;
      logic [5:0]  off, tgt;
      logic [5:0]  a;
      logic [23:0] ir;
      logic [5:0]  pc;
      bit          v, h;
   } vec_t;

   function automatic vec_t mk(bit rst, st, brel, babs, logic [5:0] off, tgt,
                               logic [5:0] a, logic [23:0] irw, logic [5:0] pc, bit v);
      vec_t r;
      r.rst = rst; r.st = st; r.brel = brel; r.babs = babs; r.off = off; r.tgt = tgt;
      r.a = a; r.ir = irw; r.pc = pc; r.v = v; r.h = 0;
      return r;
   endfunction

   vec_t tv[23];

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 24'h100 + 24'(i);

      // directed table: reset, fetch, stall at PC=5, rel branch from 10,
      // abs+rel+stall collision, negative offset, stall during squash
      tv[0]  = mk(1,0,0,0, 6'h00, 6'd0,  6'd0,  24'h000, 6'd0,  0);
      tv[1]  = mk(0,0,0,0, 6'h00, 6'd0,  6'd1,  24'h100, 6'd0,  1);
      tv[2]  = mk(0,0,0,0, 6'h00, 6'd0,  6'd2,  24'h101, 6'd1,  1);
      tv[3]  = mk(0,0,0,0, 6'h00, 6'd0,  6'd3,  24'h102, 6'd2,  1);
      tv[4]  = mk(0,0,0,0, 6'h00, 6'd0,  6'd4,  24'h103, 6'd3,  1);
      tv[5]  = mk(0,0,0,0, 6'h00, 6'd0,  6'd5,  24'h104, 6'd4,  1);
      tv[6]  = mk(0,1,0,0, 6'h00, 6'd0,  6'd5,  24'h104, 6'd4,  1);
      tv[7]  = mk(0,1,0,0, 6'h00, 6'd0,  6'd5,  24'h104, 6'd4,  1);
      tv[8]  = mk(0,1,0,0, 6'h00, 6'd0,  6'd5,  24'h104, 6'd4,  1);
      tv[9]  = mk(0,0,0,0, 6'h00, 6'd0,  6'd6,  24'h105, 6'd5,  1);
      tv[10] = mk(0,0,0,0, 6'h00, 6'd0,  6'd7,  24'h106, 6'd6,  1);
      tv[11] = mk(0,0,0,0, 6'h00, 6'd0,  6'd8,  24'h107, 6'd7,  1);
      tv[12] = mk(0,0,0,0, 6'h00, 6'd0,  6'd9,  24'h108, 6'd8,  1);
      tv[13] = mk(0,0,0,0, 6'h00, 6'd0,  6'd10, 24'h109, 6'd9,  1);
      tv[14] = mk(0,0,0,0, 6'h00, 6'd0,  6'd11, 24'h10A, 6'd10, 1);
      tv[15] = mk(0,0,1,0, 6'h3D, 6'd0,  6'd7,  24'h10A, 6'd10, 0);
      tv[16] = mk(0,0,0,0, 6'h00, 6'd0,  6'd8,  24'h107, 6'd7,  1);
      tv[17] = mk(0,1,1,1, 6'h05, 6'd40, 6'd40, 24'h107, 6'd7,  0);
      tv[18] = mk(0,0,0,0, 6'h00, 6'd0,  6'd41, 24'h128, 6'd40, 1);
      tv[19] = mk(0,0,0,0, 6'h00, 6'd0,  6'd42, 24'h129, 6'd41, 1);
      tv[20] = mk(0,0,1,0, 6'h3F, 6'd0,  6'd40, 24'h129, 6'd41, 0);
      tv[21] = mk(0,1,0,0, 6'h00, 6'd0,  6'd40, 24'h129, 6'd41, 0);
      tv[22] = mk(0,0,0,0, 6'h00, 6'd0,  6'd41, 24'h128, 6'd40, 1);

      @(negedge clk);
      for (int i = 0; i < 23; i++) begin
         cycle(tv[i].rst, tv[i].st, tv[i].brel, tv[i].babs, tv[i].off, tv[i].tgt);
         chk($sformatf("tv%0d_addr", i), 32'(address), 32'(tv[i].a));
         chk($sformatf("tv%0d_ir", i), 32'(ir), 32'(tv[i].ir));
         chk($sformatf("tv%0d_irpc", i), 32'(ir_pc), 32'(tv[i].pc));
         chk($sformatf("tv%0d_valid", i), 32'(ir_valid), 32'(tv[i].v));
         chk($sformatf("tv%0d_halted", i), 32'(halted), 32'(tv[i].h));
      end

      // relative branch from ir_pc=0 with offset -1 wraps to 63
      cycle(1, 0, 0, 0, 6'd0, 6'd0);
      cycle(0, 0, 0, 0, 6'd0, 6'd0);
      cycle(0, 0, 1, 0, 6'h3F, 6'd0);
      chk("rel_wrap_addr", 32'(address), 32'd63);

      // 70 sequential fetches from reset: wraps 63 -> 0
      cycle(1, 0, 0, 0, 6'd0, 6'd0);
      for (int k = 1; k <= 70; k++) begin
         cycle(0, 0, 0, 0, 6'd0, 6'd0);
         chk("seq_ir", 32'(ir), 32'h100 + 32'((k - 1) % 64));
         chk("seq_irpc", 32'(ir_pc), 32'((k - 1) % 64));
         chk("seq_valid", 32'(ir_valid), 32'd1);
      end

      // halt on word at 12, frozen for 20 cycles despite branch pulses
      mem[12] = HW;
      cycle(1, 0, 0, 0, 6'd0, 6'd0);
      run(13);
      chk("halt_ir", 32'(ir), 32'(HW));
      chk("halt_irpc", 32'(ir_pc), 32'd12);
      chk("halt_valid", 32'(ir_valid), 32'd1);
      chk("halt_flag", 32'(halted), 32'd1);
      run(1);
      chk("halt_valid_drop", 32'(ir_valid), 32'd0);
      for (int j = 0; j < 20; j++) begin
         cycle(0, j[0], j[1], !j[0], 6'd5, 6'd33);
         chk("halt_addr_hold", 32'(address), 32'd12);
         chk("halt_hold", 32'(halted), 32'd1);
      end
      cycle(1, 0, 0, 0, 6'd0, 6'd0);
      chk("halt_reset_addr", 32'(address), 32'd0);
      chk("halt_reset_flag", 32'(halted), 32'd0);

      // branch while the halt word is on the bus: squashed, no halt
      run(12);
      chk("pre_halt_addr", 32'(address), 32'd12);
      cycle(0, 0, 0, 1, 6'd0, 6'd20);
      chk("sq_halt_flag", 32'(halted), 32'd0);
      chk("sq_halt_addr", 32'(address), 32'd20);
      run(1);
      chk("sq_halt_ir", 32'(ir), 32'h114);
      chk("sq_halt_irpc", 32'(ir_pc), 32'd20);
      // stall over the halt word also suppresses detection until released
      cycle(0, 0, 0, 1, 6'd0, 6'd12);
      cycle(0, 1, 0, 0, 6'd0, 6'd0);
      chk("stall_halt_flag", 32'(halted), 32'd0);
      run(1);
      chk("stall_halt_release", 32'(halted), 32'd1);

      // reset asserted together with stall mid-run
      mem[12] = 24'h10C;
      cycle(1, 0, 0, 0, 6'd0, 6'd0);
      run(4);
      cycle(1, 1, 0, 0, 6'd0, 6'd0);
      chk("rst_stall_addr", 32'(address), 32'd0);
      chk("rst_stall_ir", 32'(ir), 32'd0);
      chk("rst_stall_valid", 32'(ir_valid), 32'd0);

      // randomized run against the model
      for (int i = 0; i < 64; i++)
         mem[i] = ($urandom_range(0, 7) == 0) ? HW : 24'($urandom);
      cycle(1, 0, 0, 0, 6'd0, 6'd0);
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom_range(0, 99) == 0) || (m_h && $urandom_range(0, 9) == 0),
               $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 7) == 0, 6'($urandom), 6'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
